// File: rtl/reduce_unit.sv
// Frame-wide AND/OR/XOR/NAND reduction with valid/ready on both sides.
// Optional per-frame beat counter on beat_count when REDUCE_BEATCNT_EN is defined.
module reduce_unit #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out
`ifdef REDUCE_BEATCNT_EN
    ,
    output logic [CNT_W-1:0] beat_count
`endif
);

    // state | meaning
    // IDLE  | waiting for the first beat of a frame; latches mode on accept
    // ACCUM | mid-frame; folds each beat into acc with the latched operator
    // HOLD  | result presented on out until out_ready completes the handshake

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_params
        $error("reduce_unit: WIDTH must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       acc, acc_nxt;
    logic [1:0] mode_q, mode_nxt;
    logic [1:0] op;
    logic       beat_red;

    // The first beat is reduced with the live mode, later beats with the latched one.
    always_comb begin
        op = (state == IDLE) ? mode : mode_q;
        case (op)
            OP_OR:   beat_red = |in_data;
            OP_XOR:  beat_red = ^in_data;
            default: beat_red = &in_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= 1'b0;
            mode_q <= OP_AND;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            mode_q <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        mode_nxt  = mode_q;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mode_nxt  = mode;
                    acc_nxt   = beat_red;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    case (mode_q)
                        OP_OR:   acc_nxt = acc | beat_red;
                        OP_XOR:  acc_nxt = acc ^ beat_red;
                        default: acc_nxt = acc & beat_red;
                    endcase
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out       = (mode_q == OP_NAND) ? ~acc : acc;
                if (out_ready) begin
                    state_nxt = IDLE;
                    acc_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef REDUCE_BEATCNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count; the first beat of a frame restarts it at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == HOLD) begin
            if (out_ready) cnt <= '0;
        end else if (in_valid) begin
            if (state == IDLE)  cnt <= CNT_W'(1);
            else if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end
    end

    assign beat_count = (state == HOLD) ? cnt : '0;
`endif

endmodule
